arbiter_rr_hold: RTL and testbench

- Registered round-robin arbiter that shares one resource among N_REQ requesters.
- Each winner holds the grant across multiple cycles until it releases the resource.
- Sits between requesters and a shared datapath, e.g. a bus or memory port.
- Produces a one-hot grant, an encoded owner id and a busy flag.
- Fairness: after each release, priority rotates to the requester after the last owner.

---
 rtl/arbiter_rr_hold.sv | 145 ++++++++++++++
 tb/tb_arbiter_rr_hold.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_hold.sv
// Round-robin arbiter with grant hold until the owner releases the resource.
// Optional forced release after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
//   state | meaning
//   IDLE  | no owner, arbitrate among pending requests
//   HOLD  | owner gnt_id keeps the resource until done/req drop (or forced release)
module arbiter_rr_hold #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = $clog2(N_REQ),
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    localparam int SW = ID_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  ptr, ptr_nxt, gnt_id_nxt, win_id, ptr_after;
    logic [N_REQ-1:0] gnt_nxt, win_onehot;
    logic             win_found, release_now, others_pending, force_release;

    if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
        $error("arbiter_rr_hold: N_REQ or MAX_HOLD out of range");
    end

    // First set request bit scanning upward from ptr, wrapping at N_REQ.
    always_comb begin
        logic [SW-1:0]   sum;
        logic [ID_W-1:0] cand;
        sum       = '0;
        cand      = '0;
        win_id    = ptr;
        win_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(N_REQ)) begin
                sum = sum - SW'(N_REQ);
            end
            cand = sum[ID_W-1:0];
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        win_onehot         = '0;
        win_onehot[win_id] = 1'b1;
    end

    assign release_now    = (|(done & gnt)) | ~(|(req & gnt));
    assign others_pending = |(req & ~gnt);
    assign ptr_after      = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic       timeout_q;

    assign force_release = (state == HOLD) && !release_now
                           && (hold_cnt == HOLD_LAST) && others_pending;

    // Counter runs only while the same owner stays; it saturates so a lone owner keeps the grant.
    always_comb begin
        hold_cnt_nxt = '0;
        if (state == HOLD && state_nxt == HOLD) begin
            hold_cnt_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_nxt;
            timeout_q <= force_release;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_release = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        gnt_nxt    = gnt;
        gnt_id_nxt = gnt_id;
        case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_nxt    = win_onehot;
                    gnt_id_nxt = win_id;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                if (release_now || force_release) begin
                    gnt_nxt   = '0;
                    ptr_nxt   = ptr_after;
                    state_nxt = IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            gnt    <= gnt_nxt;
            gnt_id <= gnt_id_nxt;
        end
    end

    assign gnt_valid = |gnt;
    assign busy      = gnt_valid;

endmodule

// File: tb/tb_arbiter_rr_hold.sv
// Self-checking bench for arbiter_rr_hold: directed scenarios plus random traffic against a reference model.
module tb_arbiter_rr_hold;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int MH  = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   done  = '0;
    logic [N-1:0]   gnt;
    logic           gnt_valid, busy, timeout;
    logic [IDW-1:0] gnt_id;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner index (-1 = none), rotation pointer, hold age, timeout pulse.
    int m_owner, m_ptr, m_id, m_cnt;
    bit m_to;

    always #5 clk = ~clk;

    arbiter_rr_hold #(.N_REQ(N), .ID_W(IDW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt(gnt),
        .gnt_valid(gnt_valid), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    function automatic void m_reset();
        m_owner = -1; m_ptr = 0; m_id = 0; m_cnt = 0; m_to = 1'b0;
    endfunction

    function automatic void m_update(logic [N-1:0] r, logic [N-1:0] d);
        bit rel, others, forced;
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                int idx = (m_ptr + i) % N;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx; m_id = idx; m_cnt = 0;
                end
            end
        end else begin
            rel    = d[m_owner] || !r[m_owner];
            others = (r & ~(N'(1) << m_owner)) != '0;
            forced = TO_EN && !rel && (m_cnt == MH - 1) && others;
            if (rel || forced) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_to    = forced;
            end else if (m_cnt < MH - 1) begin
                m_cnt++;
            end
        end
    endfunction

    function automatic logic [N-1:0] m_gnt();
        logic [N-1:0] v = '0;
        if (m_owner >= 0) v[m_owner] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        m_update(req, done);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; done = '0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step();
            n_tests++;
            if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || busy !== 1'b0 || gnt_id !== 2'd0 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL reset idle c%0d: gnt=%b v=%b busy=%b id=%0d to=%b, want 0000/0/0/0/0", c, gnt, gnt_valid, busy, gnt_id, timeout);
            end
        end
    endtask

    task automatic test_two_req();
        do_reset();
        req = 4'b1010;
        step();
        n_tests++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1 || gnt_valid !== 1'b1) begin
            n_fail++; $display("FAIL two_req first: gnt=%b id=%0d, want 0010 id=1", gnt, gnt_id);
        end
        done = 4'b0010;
        step();
        done = 4'b0000;
        n_tests++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd1) begin
            n_fail++; $display("FAIL two_req gap: gnt=%b v=%b id=%0d, want 0000 v=0 id=1", gnt, gnt_valid, gnt_id);
        end
        step();
        n_tests++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            n_fail++; $display("FAIL two_req second: gnt=%b id=%0d, want 1000 id=3", gnt, gnt_id);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] want;
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            want = '0; want[k % N] = 1'b1;
            n_tests++;
            if (gnt !== want || gnt_id !== IDW'(k % N)) begin
                n_fail++; $display("FAIL rotation grant%0d c1: gnt=%b id=%0d, want %b", k, gnt, gnt_id, want);
            end
            step();
            n_tests++;
            if (gnt !== want) begin
                n_fail++; $display("FAIL rotation grant%0d c2: gnt=%b, want %b", k, gnt, want);
            end
            done = want;
            step();
            done = '0;
            n_tests++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                n_fail++; $display("FAIL rotation gap%0d: gnt=%b busy=%b, want 0000/0", k, gnt, busy);
            end
            step();
        end
    endtask

    task automatic test_hold_ignore(input bit with3);
        logic [N-1:0] want_next;
        want_next = with3 ? 4'b1000 : 4'b0010;
        do_reset();
        req = 4'b0100;
        step();
        req  = with3 ? 4'b1110 : 4'b0110;
        done = 4'b1001;
        step();
        done = '0;
        n_tests++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            n_fail++; $display("FAIL hold_ignore w3=%0d stay: gnt=%b id=%0d, want 0100 id=2", with3, gnt, gnt_id);
        end
        done = 4'b0100;
        step();
        done = '0;
        step();
        n_tests++;
        if (gnt !== want_next) begin
            n_fail++; $display("FAIL hold_ignore w3=%0d next: gnt=%b, want %b", with3, gnt, want_next);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        step();
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        n_tests++;
        if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0) begin
            n_fail++; $display("FAIL async_reset: gnt=%b v=%b id=%0d, want 0000/0/0 before any edge", gnt, gnt_valid, gnt_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_tests++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            n_fail++; $display("FAIL async_reset regrant: gnt=%b id=%0d, want 0100 id=2", gnt, gnt_id);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        step();
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < MH; c++) begin
            n_tests++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL timeout hold c%0d: gnt=%b to=%b, want 0001/0", c, gnt, timeout);
            end
            step();
        end
        n_tests++;
        if (gnt !== 4'b0000 || timeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout forced: gnt=%b to=%b, want 0000/1", gnt, timeout);
        end
        step();
        n_tests++;
        if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL timeout next: gnt=%b to=%b, want 0010/0", gnt, timeout);
        end
        do_reset();
        req = 4'b0001;
        step();
`endif
        for (int c = 0; c < 3 * MH; c++) begin
            n_tests++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) begin
                n_fail++; $display("FAIL timeout keep c%0d: gnt=%b to=%b, want 0001/0", c, gnt, timeout);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] eg;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if (!req[b]) req[b] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 9) == 0) req[b] = 1'b0;
                done[b] = ($urandom_range(0, 5) == 0);
            end
            step();
            eg = m_gnt();
            n_tests++;
            if (gnt !== eg || gnt_id !== IDW'(m_id) || gnt_valid !== (eg != '0) || busy !== (eg != '0) || timeout !== m_to) begin
                n_fail++;
                $display("FAIL random c%0d: gnt=%b want %b, id=%0d want %0d, v=%b busy=%b, to=%b want %b",
                         c, gnt, eg, gnt_id, m_id, gnt_valid, busy, timeout, m_to);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_two_req();
        test_rotation();
        test_hold_ignore(1'b0);
        test_hold_ignore(1'b1);
        test_async_reset();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
